// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared encodings for the data-memory arbiter
package dm_arb_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] S_EX         = 2'd0;
    localparam logic [1:0] S_AUX_FORCED = 2'd1;
    localparam logic [1:0] S_AUX_BURST  = 2'd2;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_EX   = 2'd1,
        OWN_AUX  = 2'd2
    } owner_e;

endpackage

// File: rtl/dm_arb_rdreg.sv
// rtl/dm_arb_rdreg.sv - per-port read capture register with one-cycle valid pulse
module dm_arb_rdreg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o
);

    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= cap_i;
            if (cap_i) begin
                rdata_q <= d_i;
            end
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - single-port data memory arbiter between EX (priority) and aux
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ex_req,
    input  logic              ex_we,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              ex_stall,
    output logic [DATA_W-1:0] ex_rdata,
    output logic              ex_rvalid,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic              aux_lock,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_gnt,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              aux_rvalid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_MAX - 1);
    localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'(BURST_MAX - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    owner_e           owner, owner_g;

    always_comb begin
        owner   = OWN_NONE;
        state_d = state_q;
        burst_d = '0;
        case (state_q)
            S_EX: begin
                if (ex_req) begin
                    owner = OWN_EX;
                end else if (aux_req) begin
                    owner = OWN_AUX;
                end
                if ((owner == OWN_AUX) && aux_lock) begin
                    state_d = S_AUX_BURST;
                end else if (ex_req && aux_req && (starve_q == STARVE_LAST)) begin
                    state_d = S_AUX_FORCED;
                end
            end
            S_AUX_FORCED: begin
                // A dropped aux request hands the slot straight back to EX.
                if (aux_req) begin
                    owner = OWN_AUX;
                end else if (ex_req) begin
                    owner = OWN_EX;
                end
                state_d = (aux_req && aux_lock) ? S_AUX_BURST : S_EX;
            end
            S_AUX_BURST: begin
                if (aux_req) begin
                    owner = OWN_AUX;
                end
                if (!aux_req || !aux_lock || (burst_q == BURST_LAST)) begin
                    state_d = S_EX;
                end else begin
                    burst_d = burst_q + 1'b1;
                end
            end
            default: begin
                state_d = S_EX;
            end
        endcase
    end

    // Only a denied-but-waiting aux in S_EX advances the counter; it saturates.
    always_comb begin
        starve_d = starve_q;
        if ((owner == OWN_AUX) || !aux_req || (state_q == S_AUX_FORCED)) begin
            starve_d = '0;
        end else if (ex_req && (starve_q != STARVE_LAST)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= S_EX;
            starve_q <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            burst_q  <= burst_d;
        end
    end

    // Reset forces the memory side quiet without waiting for a clock edge.
    assign owner_g  = RESET ? owner : OWN_NONE;
    assign aux_gnt  = (owner_g == OWN_AUX);
    assign ex_stall = RESET && ex_req && (owner_g != OWN_EX);

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (owner_g)
            OWN_EX: begin
                mem_we    = ex_req & ex_we;
                mem_addr  = ex_addr;
                mem_wdata = ex_wdata;
            end
            OWN_AUX: begin
                mem_we    = aux_req & aux_we;
                mem_addr  = aux_addr;
                mem_wdata = aux_wdata;
            end
            default: begin
            end
        endcase
    end

    dm_arb_rdreg #(.DATA_W(DATA_W)) u_ex_rd (
        .clk      (CLK),
        .rst_n    (RESET),
        .cap_i    ((owner_g == OWN_EX) && !ex_we),
        .d_i      (mem_q),
        .rdata_o  (ex_rdata),
        .rvalid_o (ex_rvalid)
    );

    dm_arb_rdreg #(.DATA_W(DATA_W)) u_aux_rd (
        .clk      (CLK),
        .rst_n    (RESET),
        .cap_i    ((owner_g == OWN_AUX) && !aux_we),
        .d_i      (mem_q),
        .rdata_o  (aux_rdata),
        .rvalid_o (aux_rvalid)
    );

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed and random checks of dm_arbiter against a behavioural model
module tb_dm_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SMAX = 4;
    localparam int BMAX = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          ex_req, ex_we, aux_req, aux_we, aux_lock;
    logic [AW-1:0] ex_addr, aux_addr;
    logic [DW-1:0] ex_wdata, aux_wdata;
    logic          ex_stall, ex_rvalid, aux_gnt, aux_rvalid, mem_we;
    logic [DW-1:0] ex_rdata, aux_rdata, mem_wdata, mem_q;
    logic [AW-1:0] mem_addr;

    always #5 CLK = ~CLK;

    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .BURST_MAX(BMAX)) dut (
        .CLK(CLK), .RESET(RESET),
        .ex_req(ex_req), .ex_we(ex_we), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_stall(ex_stall), .ex_rdata(ex_rdata), .ex_rvalid(ex_rvalid),
        .aux_req(aux_req), .aux_we(aux_we), .aux_lock(aux_lock), .aux_addr(aux_addr),
        .aux_wdata(aux_wdata), .aux_gnt(aux_gnt), .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_q(mem_q)
    );

    logic [DW-1:0] ram [0:1023];
    assign mem_q = ram[mem_addr];
    always @(posedge CLK) if (mem_we) ram[mem_addr] <= mem_wdata;

    int total = 0;
    int bad = 0;

    // Model: pending forced slot, remaining burst cycles, denial count, golden memory.
    int            m_den, m_burst, m_own;
    bit            m_forced;
    logic [DW-1:0] gold [0:1023];
    logic [DW-1:0] e_exd, e_auxd;
    logic          e_exv, e_auxv;
    logic          g_seen, s_seen;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_den = 0; m_burst = 0; m_forced = 1'b0;
        e_exd = '0; e_auxd = '0; e_exv = 1'b0; e_auxv = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk1({tag, "_stall"}, ex_stall, 1'b0);
        chk1({tag, "_gnt"}, aux_gnt, 1'b0);
        chk1({tag, "_we"}, mem_we, 1'b0);
        chk({tag, "_addr"}, {22'd0, mem_addr}, '0);
        chk({tag, "_wdata"}, mem_wdata, '0);
        chk1({tag, "_exv"}, ex_rvalid, 1'b0);
        chk1({tag, "_auxv"}, aux_rvalid, 1'b0);
        chk({tag, "_exd"}, ex_rdata, '0);
        chk({tag, "_auxd"}, aux_rdata, '0);
    endtask

    task automatic set_in(input logic er, input logic ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                          input logic ar, input logic aw, input logic al, input logic [AW-1:0] aa,
                          input logic [DW-1:0] ad);
        ex_req = er; ex_we = ew; ex_addr = ea; ex_wdata = ed;
        aux_req = ar; aux_we = aw; aux_lock = al; aux_addr = aa; aux_wdata = ad;
    endtask

    // One clock: check grant/mux before the edge, advance the model at it, check reads after.
    task automatic cycle();
        logic          xw;
        logic [AW-1:0] xa;
        logic [DW-1:0] xd;
        #2;
        if (m_burst > 0)   m_own = aux_req ? 2 : 0;
        else if (m_forced) m_own = aux_req ? 2 : (ex_req ? 1 : 0);
        else               m_own = ex_req ? 1 : (aux_req ? 2 : 0);
        xw = 1'b0; xa = '0; xd = '0;
        if (m_own == 1) begin xw = ex_we; xa = ex_addr; xd = ex_wdata; end
        if (m_own == 2) begin xw = aux_we; xa = aux_addr; xd = aux_wdata; end
        g_seen = aux_gnt;
        s_seen = ex_stall;
        chk1("aux_gnt", aux_gnt, m_own == 2);
        chk1("ex_stall", ex_stall, ex_req && (m_own != 1));
        chk1("mem_we", mem_we, xw);
        chk("mem_addr", {22'd0, mem_addr}, {22'd0, xa});
        chk("mem_wdata", mem_wdata, xd);
        @(posedge CLK);
        e_exv  = (m_own == 1) && !ex_we;
        e_auxv = (m_own == 2) && !aux_we;
        if (e_exv)  e_exd  = gold[ex_addr];
        if (e_auxv) e_auxd = gold[aux_addr];
        if (xw) gold[xa] = xd;
        if (m_burst > 0) begin
            m_den = 0;
            m_burst = (aux_req && aux_lock) ? m_burst - 1 : 0;
        end else if (m_forced) begin
            m_forced = 1'b0; m_den = 0;
            if (aux_req && aux_lock) m_burst = BMAX;
        end else if (m_own == 2) begin
            m_den = 0;
            if (aux_lock) m_burst = BMAX;
        end else if (!aux_req) begin
            m_den = 0;
        end else if (m_den + 1 >= SMAX) begin
            m_forced = 1'b1;
        end else begin
            m_den++;
        end
        #1;
        chk1("ex_rvalid", ex_rvalid, e_exv);
        chk1("aux_rvalid", aux_rvalid, e_auxv);
        chk("ex_rdata", ex_rdata, e_exd);
        chk("aux_rdata", aux_rdata, e_auxd);
    endtask

    task automatic idle(input int n);
        set_in(0, 0, '0, '0, 0, 0, 0, '0, '0);
        repeat (n) cycle();
    endtask

    initial begin
        int k, first, run, found;
        logic st_hist [0:59];
        logic gn_hist [0:59];
        for (int i = 0; i < 1024; i++) begin
            ram[i] <= '0;
            gold[i] = '0;
        end
        for (int i = 0; i < 60; i++) begin st_hist[i] = 1'b0; gn_hist[i] = 1'b0; end
        RESET = 1'b0;
        set_in(0, 0, '0, '0, 0, 0, 0, '0, '0);
        model_reset();
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;

        // Warm-up traffic, then an asynchronous reset in the middle of it.
        for (int i = 0; i < 20; i++) begin
            set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   10'($urandom_range(0, 15)), $urandom);
            cycle();
        end
        set_in(1, 0, 10'h005, 32'h1, 1, 1, 1, 10'h006, 32'h2);
        #3 RESET = 1'b0;
        #1 chk_zero("t1_async");
        model_reset();
        @(posedge CLK);
        #1 chk_zero("t1_held");
        RESET = 1'b1;
        idle(1);

        // EX write then read back.
        set_in(1, 1, 10'h010, 32'hDEADBEEF, 0, 0, 0, '0, '0);
        cycle();
        set_in(1, 0, 10'h010, '0, 0, 0, 0, '0, '0);
        cycle();
        chk1("t2_stall", s_seen, 1'b0);
        chk1("t2_rvalid", ex_rvalid, 1'b1);
        chk("t2_rdata", ex_rdata, 32'hDEADBEEF);
        chk1("t2_aux_rvalid", aux_rvalid, 1'b0);
        idle(2);

        // Continuous contention: one forced aux slot every SMAX+1 cycles.
        for (int i = 0; i < 15; i++) begin
            set_in(1, 0, 10'($urandom_range(0, 31)), '0, 1, 0, 0, 10'($urandom_range(0, 31)), '0);
            cycle();
            chk1("t3_gnt", g_seen, (i % 5) == 4);
            chk1("t3_stall", s_seen, (i % 5) == 4);
        end
        idle(2);

        // Locked aux burst of writes under EX contention.
        k = 0;
        for (int c = 0; c < 60 && k < 10; c++) begin
            set_in(1, 0, 10'h100, '0, 1, 1, 1, 10'(k), 32'(k + 1));
            cycle();
            gn_hist[c] = g_seen;
            st_hist[c] = s_seen;
            if (g_seen) k++;
        end
        first = -1;
        for (int c = 59; c >= 0; c--) if (gn_hist[c]) first = c;
        run = 0;
        if (first >= 0) while (first + run < 60 && gn_hist[first + run]) run++;
        chk("t4_first_grant", 32'(first), 32'd4);
        chk("t4_run_len", 32'(run), 32'(1 + BMAX));
        if (first >= 0 && first + run < 60)
            chk1("t4_release_stall", st_hist[first + run], 1'b0);
        else
            chk1("t4_release_found", 1'b0, 1'b1);
        chk("t4_writes", 32'(k), 32'd10);
        idle(2);
        for (int i = 0; i < 10; i++) chk("t4_mem", ram[i], 32'(i + 1));

        // Forced-slot aux read, request dropped right after.
        set_in(1, 1, 10'h3FF, 32'h12345678, 0, 0, 0, '0, '0);
        cycle();
        idle(2);
        found = -1;
        for (int c = 0; c < 10 && found < 0; c++) begin
            set_in(1, 0, 10'h020, '0, 1, 0, 0, 10'h3FF, '0);
            cycle();
            if (g_seen) found = c;
        end
        chk("t5_forced_at", 32'(found), 32'd4);
        chk1("t5_rvalid", aux_rvalid, 1'b1);
        chk("t5_rdata", aux_rdata, 32'h12345678);
        set_in(1, 0, 10'h020, '0, 0, 0, 0, '0, '0);
        cycle();
        chk1("t5_ex_served", s_seen, 1'b0);
        chk1("t5_rvalid_drop", aux_rvalid, 1'b0);
        idle(2);

        // Reset inside a burst with an aux read about to be captured.
        set_in(0, 0, '0, '0, 1, 0, 1, 10'h3FF, '0);
        cycle();
        #2 chk1("t6_burst_gnt", aux_gnt, 1'b1);
        RESET = 1'b0;
        #1 chk_zero("t6_async");
        model_reset();
        @(posedge CLK);
        #1 chk_zero("t6_held");
        RESET = 1'b1;
        set_in(1, 0, 10'h3FF, '0, 0, 0, 0, '0, '0);
        cycle();
        chk1("t6_ex_gnt", s_seen, 1'b0);
        chk1("t6_no_aux_rvalid", aux_rvalid, 1'b0);
        chk1("t6_ex_rvalid", ex_rvalid, 1'b1);

        // Random traffic over a small address window.
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                   10'($urandom_range(0, 15)), $urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port data memory between two requesters: the EX stage load/store path (primary) and an auxiliary port used by the program loader and debug dump (secondary).
- Sits between the EX stage and data_memory, replacing the direct WE/ADDRESS/DATA hookup.
- EX has fixed priority. A starvation counter guarantees the aux port a slot, and EX is stalled for that cycle.
- Aux may lock the memory for bounded bursts.

Parameters:
- ADDR_W, 10, memory word-address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive denied aux cycles before a forced aux grant (legal 1..15)
- BURST_MAX, 8, maximum consecutive aux-owned cycles under lock (legal 1..15)

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- ex_req  in  1  EX requests memory access this cycle
- ex_we  in  1  1 = write, 0 = read
- ex_addr  in  ADDR_W  EX word address
- ex_wdata  in  DATA_W  EX write data
- ex_stall  out  1  EX request not served this cycle; hold request
- ex_rdata  out  DATA_W  registered read data for EX
- ex_rvalid  out  1  ex_rdata valid (one cycle pulse)
- aux_req  in  1  aux request
- aux_we  in  1  aux write
- aux_lock  in  1  aux asks to keep ownership after the current grant
- aux_addr  in  ADDR_W  aux word address
- aux_wdata  in  DATA_W  aux write data
- aux_gnt  out  1  aux access performed this cycle
- aux_rdata  out  DATA_W  registered read data for aux
- aux_rvalid  out  1  aux_rdata valid pulse
- mem_we  out  1  to data_memory WE
- mem_addr  out  ADDR_W  to data_memory ADDRESS
- mem_wdata  out  DATA_W  to data_memory DATA
- mem_q  in  DATA_W  data_memory Q; combinational read of mem_addr

Behaviour:
Grant selection
- Grant decision is combinational from the current state and requests.
- Exactly one owner drives mem_* per cycle.
- When no owner, mem_we=0 and mem_addr/mem_wdata=0.
- Write-enable gating: mem_we = owner_req & owner_we. A non-owner can never write.

State machine
- S_EX (reset state):
  - If ex_req: EX owns, ex_stall=0.
  - Else if aux_req: aux owns, aux_gnt=1.
  - If aux owns and aux_lock=1: go to S_AUX_BURST.
  - If ex_req & aux_req: aux is denied and starve_cnt increments.
  - When starve_cnt reaches STARVE_MAX-1 and aux is denied again: go to S_AUX_FORCED.
- S_AUX_FORCED (exactly 1 cycle):
  - If aux_req: aux owns, aux_gnt=1, ex_stall=ex_req.
  - starve_cnt clears.
  - Next state is S_AUX_BURST if aux_req & aux_lock, else S_EX.
  - If aux_req has dropped: no grant, and EX is not stalled.
- S_AUX_BURST:
  - aux owns whenever aux_req=1; ex_stall=ex_req.
  - burst_cnt counts cycles spent in this state.
  - Exit to S_EX on aux_lock=0, aux_req=0, or burst_cnt=BURST_MAX-1 (forced release).
  - After a forced release, the first S_EX cycle always serves EX if ex_req (no immediate re-entry).
- starve_cnt clears on any aux grant and whenever aux_req=0. It saturates and never wraps.

Read data
- On a granted read, mem_q is captured into the owner's rdata register at the clock edge.
- The owner's rvalid pulses high for the next cycle only. Read latency is 1 cycle after grant.
- rdata holds its last value when rvalid=0.
- A granted write gives no rvalid.

Simultaneous events and reset
- ex_stall=1 only when ex_req=1 and EX is not owner. ex_stall=0 otherwise, including when idle.
- Same-address writes in consecutive cycles by different owners both reach memory in grant order.
- RESET low, at any time including mid-burst:
  - state=S_EX, counters=0
  - ex_rvalid=aux_rvalid=0, ex_rdata=aux_rdata=0
  - aux_gnt=0, ex_stall=0, mem_we=0 (driven asynchronously)
  - Any in-flight read is dropped.

Decomposition:
- Shared package dm_arb_pkg:
  - state encoding (S_EX=2'd0, S_AUX_FORCED=2'd1, S_AUX_BURST=2'd2)
  - owner enum (OWN_NONE, OWN_EX, OWN_AUX)
  - counter width constant CNT_W=4
- One natural sub-module: dm_arb_rdreg. It is the per-port read-capture register with its rvalid pulse, instantiated twice.
- The FSM and mux stay in dm_arbiter.

Test Plan:
1. Reset with RESET=0 mid-traffic:
   - All outputs are zero immediately, before any clock edge.
   - After release with idle inputs: state S_EX, no grants.
2. EX write 0xDEADBEEF @0x010, then EX read @0x010:
   - Read is granted with ex_stall=0.
   - Next cycle ex_rvalid=1, ex_rdata=0xDEADBEEF.
   - aux_rvalid stays 0.
3. ex_req and aux_req held continuously (STARVE_MAX=4):
   - EX is granted in cycles 0-3.
   - Cycle 4: aux_gnt=1, ex_stall=1.
   - Cycle 5: EX is granted again and starve_cnt=0.
   - The pattern repeats every 5 cycles.
4. Aux burst: aux_lock=1 with aux writes 1..10 to @0x000..0x009 while ex_req=1 (BURST_MAX=8):
   - First entry: with EX contending, aux gets its first grant only after 4 denials (forced slot).
   - Aux then writes 8 words with ex_stall=1 throughout.
   - Forced release: the next cycle serves EX.
   - Aux resumes after later starvation. Memory ends with @0x000..0x009 = 1..10.
5. Aux read @0x3FF = 0x12345678 in S_AUX_FORCED with aux_req dropping the following cycle:
   - aux_rvalid=1 and aux_rdata=0x12345678 one cycle later.
   - State returns to S_EX.
6. RESET asserted during S_AUX_BURST with a read pending:
   - No rvalid pulse after release.
   - State S_EX; EX is granted on the first request.
